// File: rtl/fpadd_issue_sequencer_pkg.sv
// Shared definitions for the fpadd issue sequencer and the adder wrapper.
//   seq_state_e   : sequencer FSM states
//   FPADD_LATENCY : fpadd pipeline depth in ce-enabled cycles. The sequencer
//                   and the adder wrapper both use it, so their timing agrees.
//   OP_ADD/OP_SUB : encoding of the add/subtract select
package fpadd_issue_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int unsigned FPADD_LATENCY = 7;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fpadd_issue_sequencer_valid_tag_pipe.sv
// valid_tag_pipe: a one-bit valid tag that shadows a pipelined FP unit.
// It shifts only while the unit's clock enable is high, so the tag leaves the
// top of the pipe in the same cycle as the data it tracks.
//   clk, rst_n : clock and asynchronous active-low reset
//   shift_en   : advance the pipe (the unit's ce)
//   tag_in     : tag loaded into bit 0 on a shift
//   tag_out    : top bit, i.e. the result-valid strobe
//   any_set    : at least one tag is still in flight
module valid_tag_pipe #(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_en,
    input  logic tag_in,
    output logic tag_out,
    output logic any_set
);

    logic [DEPTH-1:0] tag_q;
    logic [DEPTH-1:0] tag_d;

    // NOTE: the hold value is assigned first, so a path that does not shift
    // still assigns tag_d and no latch is inferred.
    always_comb begin
        tag_d = tag_q;
        if (shift_en) begin
            tag_d = {tag_q[DEPTH-2:0], tag_in};
        end
    end

    // NOTE: this shift register is reset even though it only holds flags.
    // If a run is aborted, stale tags would otherwise appear later as
    // phantom result strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            // NOTE: non-blocking, so every stage samples the pre-edge value of
            // its neighbour and the pipe shifts by exactly one.
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q[DEPTH-1];
    assign any_set = |tag_q;

endmodule

// File: rtl/fpadd_issue_sequencer.sv
// fpadd_issue_sequencer: feeds operand pairs into the pipelined fpadd.
// It takes `length` pairs through a valid/ready handshake. Each accepted pair
// is registered onto add_a/add_b, and its valid tag is tracked through the
// adder pipeline so that outsider15 marks the matching result. A single-cycle
// `done` pulse follows the last result.
//   start/length/op_mode : run request, sampled only in IDLE
//   in_valid/in_ready    : upstream operand handshake
//   in_a/in_b            : operand pair
//   add_a/add_b/add_op   : registered operands and op select to fpadd
//   add_ce               : adder clock enable (high in ISSUE and DRAIN)
//   add_start            : wrapper start level; low clears its hold register
//   outsider15           : result-valid strobe to the wrapper
//   busy/done/issued     : run status
module fpadd_issue_sequencer
    import fpadd_issue_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = FPADD_LATENCY,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] length,
    input  logic               op_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_op,
    output logic               add_ce,
    output logic               add_start,
    output logic               outsider15,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] issued
);

    seq_state_e         state_q, state_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic [COUNT_W-1:0] issued_q, issued_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic handshake;
    logic tags_in_flight;

    assign in_ready  = (state_q == ST_ISSUE);
    assign handshake = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        len_d    = length;
                        op_d     = op_mode;
                        issued_d = '0;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    a_d = in_a;
                    b_d = in_b;
                    // The guard keeps issued from wrapping, even for length = all ones.
                    if (issued_q != len_q) begin
                        issued_d = issued_q + COUNT_W'(1);
                    end
                    if (issued_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Looks at the registered tracker, so the last tag has
                // already left the pipe before DONE is entered.
                if (!tags_in_flight) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            issued_q <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign add_ce    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign busy      = (state_q != ST_IDLE);
    assign add_start = busy;
    assign done      = (state_q == ST_DONE);
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_op    = op_q;
    assign issued    = issued_q;

    // One extra stage, because add_a/add_b register the operands before
    // they enter the LATENCY-deep adder.
    valid_tag_pipe #(
        .DEPTH(LATENCY + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_en(add_ce),
        .tag_in  (handshake),
        .tag_out (outsider15),
        .any_set (tags_in_flight)
    );

endmodule

// File: tb/tb_fpadd_issue_sequencer.sv
// Scoreboard bench for fpadd_issue_sequencer. The driver works at run level:
// it predicts the state phases, the handshake cycles, the result-strobe
// cycles and the done cycle, and pushes each prediction into a queue. A
// negedge monitor pops these queues and compares them with the DUT outputs.
module tb_fpadd_issue_sequencer;

    localparam int LAT = 7;
    localparam int W   = 32;
    localparam int CW  = 16;

    typedef struct {
        int   cyc;
        logic op;
    } tag_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } opd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] length;
    logic          op_mode;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [W-1:0]  add_a, add_b;
    logic          add_op, add_ce, add_start, outsider15, busy, done;
    logic [CW-1:0] issued;

    fpadd_issue_sequencer #(
        .WIDTH  (W),
        .LATENCY(LAT),
        .COUNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .length    (length),
        .op_mode   (op_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_op    (add_op),
        .add_ce    (add_ce),
        .add_start (add_start),
        .outsider15(outsider15),
        .busy      (busy),
        .done      (done),
        .issued    (issued)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected values for the current cycle, set by the driver just after
    // each posedge.
    logic          exp_ready = 1'b0;
    logic          exp_ce    = 1'b0;
    logic          exp_busy  = 1'b0;
    logic          exp_op    = 1'b0;
    logic [CW-1:0] exp_issued = '0;
    bit            chk_issued = 1'b1;

    tag_t tag_q[$];
    int   done_q[$];
    opd_t opd_q[$];
    bit   valid_pat[$];
    logic [W-1:0] pat_a[$];
    logic [W-1:0] pat_b[$];

    logic [W-1:0] ref_a = '0;
    logic [W-1:0] ref_b = '0;

    int n_checks = 0;
    int n_errors = 0;
    bit finish_req = 1'b0;
    bit fin_done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the DUT outputs with the predictions for this cycle.
    always @(negedge clk) begin
        while (opd_q.size() > 0 && opd_q[0].cyc <= cyc) begin
            ref_a = opd_q[0].a;
            ref_b = opd_q[0].b;
            void'(opd_q.pop_front());
        end
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("add_ce", 32'(add_ce), 32'(exp_ce));
        check("busy", 32'(busy), 32'(exp_busy));
        check("add_start", 32'(add_start), 32'(exp_busy));
        check("add_op", 32'(add_op), 32'(exp_op));
        check("add_a", add_a, ref_a);
        check("add_b", add_b, ref_b);
        if (chk_issued) check("issued", 32'(issued), 32'(exp_issued));

        if (tag_q.size() > 0 && tag_q[0].cyc == cyc) begin
            check("outsider15", 32'(outsider15), 32'd1);
            check("outsider15_op", 32'(add_op), 32'(tag_q[0].op));
            void'(tag_q.pop_front());
        end else begin
            check("outsider15_quiet", 32'(outsider15), 32'd0);
        end

        if (done_q.size() > 0 && done_q[0] == cyc) begin
            check("done", 32'(done), 32'd1);
            void'(done_q.pop_front());
        end else begin
            check("done_quiet", 32'(done), 32'd0);
        end

        if (finish_req && !fin_done) begin
            check("tags_pending", 32'(tag_q.size()), 32'd0);
            check("done_pending", 32'(done_q.size()), 32'd0);
            fin_done = 1'b1;
        end
    end

    // Reset in the middle of a run: all predictions are dropped and every
    // output is expected to read zero in the same cycle.
    task automatic do_abort();
        opd_t z;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        tag_q.delete();
        done_q.delete();
        opd_q.delete();
        z.cyc = cyc; z.a = '0; z.b = '0;
        opd_q.push_back(z);
        exp_ready = 0; exp_ce = 0; exp_busy = 0; exp_op = 0;
        exp_issued = '0; chk_issued = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        // Any leftover tag would show up in this window as a stray strobe.
        repeat (12) begin @(posedge clk); #1; end
    endtask

    // One run. pct is the in_valid probability when no pattern is queued.
    // poke pulses start while the run is issuing. abort_at >= 0 asserts reset
    // in that drain cycle.
    task automatic run(input int n, input bit op, input int pct,
                       input bit poke, input int abort_at);
        int hs_cnt = 0;
        int last_k = 0;
        int guard  = 0;
        bit poked  = 1'b0;
        tag_t t;
        opd_t o;
        @(posedge clk); #1;
        start = 1'b1; length = CW'(n); op_mode = op; in_valid = 1'b0;
        if (n == 0) begin
            chk_issued = 1'b0;
            @(posedge clk); #1;
            start = 1'b0; length = '0;
            done_q.push_back(cyc);
            exp_busy = 1'b1;
            @(posedge clk); #1;
            exp_busy = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start = 1'b0; length = CW'($urandom);
        chk_issued = 1'b1; exp_issued = '0; exp_op = op;
        exp_busy = 1'b1; exp_ce = 1'b1; exp_ready = 1'b1;
        while (hs_cnt < n) begin
            bit v;
            if (valid_pat.size() > 0) v = valid_pat.pop_front();
            else v = ($urandom_range(99) < pct) || (guard > 50);
            guard++;
            in_valid = v;
            in_a = $urandom();
            in_b = $urandom();
            if (v && pat_a.size() > 0) in_a = pat_a.pop_front();
            if (v && pat_b.size() > 0) in_b = pat_b.pop_front();
            if (poke && hs_cnt >= 1 && !poked) begin
                start = 1'b1; length = CW'(2); op_mode = ~op; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (v) begin
                t.cyc = cyc + 1 + LAT; t.op = op;
                tag_q.push_back(t);
                o.cyc = cyc + 1; o.a = in_a; o.b = in_b;
                opd_q.push_back(o);
                hs_cnt++;
                last_k = cyc;
            end
            @(posedge clk); #1;
            exp_issued = CW'(hs_cnt);
        end
        // In DRAIN, in_valid and start are driven with noise that must be ignored.
        start = 1'b0;
        exp_ready = 1'b0;
        done_q.push_back(last_k + LAT + 3);
        for (int c = 0; c < LAT + 2; c++) begin
            if (c == abort_at) begin
                do_abort();
                return;
            end
            in_valid = 1'($urandom_range(1));
            in_a = $urandom();
            in_b = $urandom();
            @(posedge clk); #1;
        end
        exp_ce = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_busy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; length = '0; op_mode = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;

        // Back-to-back run of four pairs: (1,2) (3,4) (0.5,0.5) (-1,1).
        valid_pat = '{1, 1, 1, 1};
        pat_a = '{32'h3F80_0000, 32'h4040_0000, 32'h3F00_0000, 32'hBF80_0000};
        pat_b = '{32'h4000_0000, 32'h4080_0000, 32'h3F00_0000, 32'h3F80_0000};
        run(4, 1'b0, 100, 1'b0, -1);

        // Bubbles: in_valid pattern 1,0,0,1,1 with length 3.
        valid_pat = '{1, 0, 0, 1, 1};
        run(3, 1'b0, 100, 1'b0, -1);
        valid_pat.delete();

        // Zero length: done on the next cycle, nothing issued.
        run(0, 1'b0, 100, 1'b0, -1);

        // A start pulse during ISSUE must not disturb the run of nine.
        run(9, 1'b0, 70, 1'b1, -1);

        // Subtract of a single pair (5.0, 3.0).
        pat_a = '{32'h40A0_0000};
        pat_b = '{32'h4040_0000};
        run(1, 1'b1, 100, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            run(int'($urandom_range(6, 1)), 1'($urandom_range(1)), 50, 1'b0, -1);
        end

        // Reset in DRAIN with three tags in flight, then recovery.
        run(3, 1'b1, 100, 1'b0, 1);
        run(2, 1'b0, 60, 1'b0, -1);

        finish_req = 1'b1;
        wait (fin_done);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpadd_issue_sequencer.md
# fpadd_issue_sequencer

Drives operand pairs into the pipelined floating-point adder (`fpadd`, wrapped with hold/gating control) and generates the matching result-valid strobe (`outsider15`) and `start` level that wrapper consumes. It accepts a stream of IEEE-754 single-precision pairs through a valid/ready handshake, issues a programmed number of them, and tracks each one through the adder pipeline. It signals `done` once the last result has emerged. It sits between the Jacobi cluster's operand buffers and the controlled adder.

## Interface
Parameters:
- `WIDTH`, 32: operand width (IEEE-754 single).
- `LATENCY`, 7: `fpadd` pipeline depth in `ce`-enabled cycles.
- `COUNT_W`, 16: width of the element counter.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a run; sampled only in IDLE.
- `length` input COUNT_W: number of pairs in the run; sampled with `start`.
- `op_mode` input 1: add/subtract select for the run; sampled with `start`.
- `in_valid` input 1: an upstream operand pair is present.
- `in_ready` output 1: the sequencer accepts a pair this cycle.
- `in_a`, `in_b` input WIDTH: the operand pair.
- `add_a`, `add_b` output WIDTH: registered operands to `fpadd`.
- `add_op` output 1: registered `op_mode`.
- `add_ce` output 1: adder clock enable.
- `add_start` output 1: level to the adder wrapper's `start`. Low clears its hold register.
- `outsider15` output 1: result-valid strobe to the adder wrapper.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at end of run.
- `issued` output COUNT_W: pairs accepted so far in the current run.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- **IDLE**
  - `start`=1 with `length`>0: latch `length` and `op_mode`, clear `issued`, go to ISSUE.
  - `start`=1 with `length`=0: go to DONE directly. No issue, no `outsider15`.
- **ISSUE**
  - `in_ready`=1.
  - Handshake is `in_valid & in_ready`. On handshake, register `in_a` and `in_b` into `add_a` and `add_b`, and increment `issued`.
  - When the handshake makes `issued` equal the latched length, go to DRAIN.
  - Cycles without a handshake inject a bubble. `add_a` and `add_b` hold their values, and a 0 tag enters the tracker.
- **DRAIN**
  - `in_ready`=0.
  - Stay until the tag tracker holds no 1s, then go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **Tag tracker**: shift register, LATENCY+1 bits.
  - Bit 0 loads the handshake flag.
  - It shifts every cycle that `add_ce`=1.
  - `outsider15` = its top bit.
- **Outputs by state**
  - `add_ce`=1 in ISSUE and DRAIN; 0 in IDLE and DONE.
  - `add_start`=1 from the cycle after accepting `start` through DONE; 0 in IDLE.
- `start` outside IDLE is ignored. It has no effect on `length`, `op_mode` or state.
- `issued` saturates at the latched length. It holds its value through DONE and IDLE until the next accepted `start`.

## Timing
- **Reset values**: state IDLE; all outputs 0, including `add_a`, `add_b`, `issued` and the tag tracker.
- Reset asserted mid-run aborts immediately. In-flight tags are discarded, and `add_start` falls, so the wrapper clears its hold register.
- **Latency**:
  - A handshake in cycle k gives `outsider15`=1 in cycle k+1+LATENCY.
  - This holds when no `add_ce` gap occurs, which is the case within one run.
- **Throughput**: one pair per cycle when `in_valid` is held high.
- **Run length**: a run of N back-to-back pairs started in cycle s gives `done` in cycle s+N+LATENCY+3.
  - ISSUE entry is at s+1.
  - The last handshake is at s+N.
  - DRAIN ends when the last tag exits.
- DRAIN entry and the last `outsider15` may coincide with the tracker emptying. Exit is evaluated on the registered tracker after the shift.
- Minimum `length`=1. `length`=2^COUNT_W−1 must not overflow `issued`.

## Structure
- The shared package holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the `FPADD_LATENCY` constant, so this block and the adder wrapper agree;
  - the `OP_ADD`=0 and `OP_SUB`=1 constants.
- Sub-module `valid_tag_pipe`:
  - parameterised depth with a shift-enable;
  - outputs the top bit and an "any set" flag;
  - reusable for the other pipelined FP units.

## Test plan
- **Back-to-back run**: reset; `length`=4, `op_mode`=0, `in_valid` held high, pairs (1.0,2.0), (3.0,4.0), (0.5,0.5), (−1.0,1.0).
  - `issued`=4.
  - `outsider15` high for 4 consecutive cycles starting k+8, with LATENCY=7.
  - `done` at s+14.
- **Bubbles**: `length`=3; `in_valid` pattern 1,0,0,1,1.
  - `outsider15` pattern matches 1,0,0,1,1 delayed by 8 cycles.
  - `add_a` holds its value during the bubbles.
- **Zero length**: `start` with `length`=0.
  - `done` the next cycle.
  - `add_ce`, `outsider15` and `in_ready` never assert.
- **Start ignored when busy**: `start` pulsed during ISSUE with `length`=9.
  - The run completes with the original `length`.
  - `issued` is unchanged by the pulse.
- **Reset mid-run**: `rst_n` low during DRAIN with 3 tags in flight.
  - All outputs 0 immediately and `add_start`=0.
  - No `outsider15` after release.
- **Subtract**: `op_mode`=1, pair (5.0,3.0).
  - `add_op`=1 throughout the run.
  - `outsider15` one cycle at k+8.
